// File: rtl/chip_checker_pkg.sv
// rtl/chip_checker_pkg.sv - shared types and constants for the chip checker
// Sequencer state encoding, tester slot indices and timeout counter width.
package chip_checker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RUN_WAIT,
    CAPTURE,
    RELEASE,
    REPORT
  } seq_state_t;

  localparam int CHIP_7400  = 0;
  localparam int CHIP_7474  = 1;
  localparam int CHIP_7402  = 2;
  localparam int CHIP_7404  = 3;
  localparam int CHIP_7408  = 4;
  localparam int CHIP_7432  = 5;
  localparam int CHIP_7486  = 6;
  localparam int CHIP_74138 = 7;

  localparam int TIMEOUT_W = 13;

endpackage

// File: rtl/chip_test_sequencer_if.sv
// rtl/chip_test_sequencer_if.sv - operator, display and tester-bank signals of the sequencer
// master is the sequencer side, slave is the board/tester side.
interface chip_test_sequencer_if #(
  parameter int NUM_CHIPS = 8,
  parameter int SEL_W     = $clog2(NUM_CHIPS)
);

  logic                 Start;
  logic [SEL_W-1:0]     Chip_Sel;
  logic                 Ack;
  logic [NUM_CHIPS-1:0] Done_i;
  logic [NUM_CHIPS-1:0] Rslt_i;
  logic [NUM_CHIPS-1:0] Run_o;
  logic [NUM_CHIPS-1:0] Disp_Rslt_o;
  logic [SEL_W-1:0]     Pin_Sel;
  logic                 Busy;
  logic                 Result_Valid;
  logic                 Pass;
  logic                 Timeout;
  logic                 Bad_Sel;

  modport master (
    input  Start, Chip_Sel, Ack, Done_i, Rslt_i,
    output Run_o, Disp_Rslt_o, Pin_Sel, Busy, Result_Valid, Pass, Timeout, Bad_Sel
  );

  modport slave (
    output Start, Chip_Sel, Ack, Done_i, Rslt_i,
    input  Run_o, Disp_Rslt_o, Pin_Sel, Busy, Result_Valid, Pass, Timeout, Bad_Sel
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - vector two-flop synchronizer with asynchronous active-low clear
// Each bit is synchronized independently; no cross-bit coherency is implied.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// rtl/chip_test_sequencer.sv - runs one Run/Done/DISP_RSLT handshake with the selected tester
// Holds the captured pass/fail result for the display until it is acknowledged.
module chip_test_sequencer
  import chip_checker_pkg::*;
#(
  parameter int NUM_CHIPS      = 8,
  parameter int SEL_W          = $clog2(NUM_CHIPS),
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic                   Clk,
  input logic                   Reset,
  chip_test_sequencer_if.master bus
);

  localparam logic [SEL_W:0]     NUM_SEL     = (SEL_W+1)'(NUM_CHIPS);
  localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LIM     = TIMEOUT_W'(TIMEOUT_CYCLES);

  seq_state_t           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 bad_sel_q, bad_sel_d;

  logic [NUM_CHIPS-1:0] done_s;
  logic [NUM_CHIPS-1:0] rslt_s;
  logic [NUM_CHIPS-1:0] sel_oh;
  logic [NUM_CHIPS-1:0] run;
  logic [NUM_CHIPS-1:0] disp;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 done_sel;
  logic                 rslt_sel;
  logic                 busy;
  logic                 result_valid;

  sync_2ff #(.W(NUM_CHIPS)) u_done_sync (
    .clk  (Clk),
    .rst_n(Reset),
    .d    (bus.Done_i),
    .q    (done_s)
  );

  sync_2ff #(.W(NUM_CHIPS)) u_rslt_sync (
    .clk  (Clk),
    .rst_n(Reset),
    .d    (bus.Rslt_i),
    .q    (rslt_s)
  );

  // An out-of-range select shifts out to zero, so a bad index can never drive a tester.
  assign sel_oh   = NUM_CHIPS'(1) << sel_q;
  assign done_sel = |(done_s & sel_oh);
  assign rslt_sel = |(rslt_s & sel_oh);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    bad_sel_d    = bad_sel_q;
    run          = '0;
    disp         = '0;
    busy         = 1'b1;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.Start) begin
          sel_d     = bus.Chip_Sel;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          if ({1'b0, bus.Chip_Sel} >= NUM_SEL) begin
            bad_sel_d = 1'b1;
            state_d   = REPORT;
          end else begin
            bad_sel_d = 1'b0;
            state_d   = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = RUN_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN_WAIT: begin
        run = sel_oh;
        if (done_sel) begin
          state_d = CAPTURE;
        end else if (cnt_inc >= TMO_LIM) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = REPORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      CAPTURE: begin
        pass_d  = rslt_sel;
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        disp = sel_oh;
        if (!done_sel) begin
          state_d = REPORT;
        end else if (cnt_inc >= TMO_LIM) begin
          timeout_d = 1'b1;
          state_d   = REPORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPORT: begin
        result_valid = 1'b1;
        if (bus.Ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      bad_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      bad_sel_q <= bad_sel_d;
    end
  end

  // Run/Disp are decoded from the async-reset state, so they fall as soon as Reset asserts.
  assign bus.Run_o        = run;
  assign bus.Disp_Rslt_o  = disp;
  assign bus.Pin_Sel      = sel_q;
  assign bus.Busy         = busy;
  assign bus.Result_Valid = result_valid;
  assign bus.Pass         = pass_q;
  assign bus.Timeout      = timeout_q;
  assign bus.Bad_Sel      = bad_sel_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb/tb_chip_test_sequencer.sv - scoreboard bench for chip_test_sequencer
// Tester behaviour per run is chosen at random; expected reports are queued and checked by a monitor.
module tb_chip_test_sequencer;

  localparam int NUM    = 8;
  localparam int SW     = 4;
  localparam int SETTLE = 2;
  localparam int TMO    = 200;

  localparam int M_OK    = 0;
  localparam int M_NEVER = 1;
  localparam int M_STUCK = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  chip_test_sequencer_if #(.NUM_CHIPS(NUM), .SEL_W(SW)) bus ();

  chip_test_sequencer #(
    .NUM_CHIPS     (NUM),
    .SEL_W         (SW),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int sel;
    bit bad;
    bit pass;
    bit tmo;
    int run_cyc;
    int disp_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Tester model: Done rises t_d cycles after Run is seen, falls t_h cycles after DISP_RSLT.
  logic [2:0] t_idx   = 3'd0;
  int         t_mode  = M_OK;
  int         t_d     = 1;
  int         t_h     = 1;
  bit         t_r     = 1'b0;
  bit         t_abort = 1'b0;
  int         t_phase = 0;
  int         t_cnt   = 0;

  always @(negedge clk) begin
    if (!rst_n || t_abort) begin
      bus.Done_i = '0;
      bus.Rslt_i = '0;
      t_phase    = 0;
      t_abort    = 1'b0;
    end else begin
      case (t_phase)
        0: if (bus.Run_o[t_idx]) begin
          if (t_mode == M_NEVER) begin
            bus.Rslt_i[t_idx] = 1'b1;
            t_phase = 4;
          end else begin
            t_cnt = t_d - 1;
            if (t_cnt == 0) begin
              bus.Done_i[t_idx] = 1'b1;
              bus.Rslt_i[t_idx] = t_r;
              t_phase = 2;
            end else t_phase = 1;
          end
        end
        1: begin
          t_cnt--;
          if (t_cnt == 0) begin
            bus.Done_i[t_idx] = 1'b1;
            bus.Rslt_i[t_idx] = t_r;
            t_phase = 2;
          end
        end
        2: if (bus.Disp_Rslt_o[t_idx] && t_mode != M_STUCK) begin
          t_cnt = t_h - 1;
          if (t_cnt == 0) begin
            bus.Done_i[t_idx] = 1'b0;
            t_phase = 5;
          end else t_phase = 3;
        end
        3: begin
          t_cnt--;
          if (t_cnt == 0) begin
            bus.Done_i[t_idx] = 1'b0;
            t_phase = 5;
          end
        end
        default: ;
      endcase
    end
  end

  // Monitor: tallies Run/DISP_RSLT cycles per test and checks each report against the queue head.
  int       run_cnt = 0;
  int       disp_cnt = 0;
  int       viol = 0;
  bit       rv_prev = 1'b0;
  exp_t     got_e;
  logic [NUM-1:0] exp_oh;
  logic [NUM-1:0] act_oh;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_cnt  = 0;
      disp_cnt = 0;
      viol     = 0;
      rv_prev  = 1'b0;
    end else begin
      exp_oh = '0;
      if (exp_q.size() > 0 && !exp_q[0].bad) exp_oh[exp_q[0].sel] = 1'b1;
      act_oh = bus.Run_o | bus.Disp_Rslt_o;
      if (act_oh != '0 && act_oh != exp_oh) viol++;
      if (bus.Run_o != '0) run_cnt++;
      if (bus.Disp_Rslt_o != '0) disp_cnt++;
      if (bus.Result_Valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_report", 1, 0);
        end else begin
          got_e = exp_q.pop_front();
          check("pass", bus.Pass, got_e.pass);
          check("timeout", bus.Timeout, got_e.tmo);
          check("bad_sel", bus.Bad_Sel, got_e.bad);
          check("pin_sel", bus.Pin_Sel, got_e.sel);
          check("run_cycles", run_cnt, got_e.run_cyc);
          check("disp_cycles", disp_cnt, got_e.disp_cyc);
          check("onehot_violations", viol, 0);
        end
        run_cnt  = 0;
        disp_cnt = 0;
        viol     = 0;
      end
      rv_prev = bus.Result_Valid;
    end
  end

  function automatic exp_t make_exp(input int sel, input int mode, input int d, input int h, input bit r);
    exp_t e;
    e.sel = sel;
    e.bad = (sel >= NUM);
    e.pass = 1'b0; e.tmo = 1'b0; e.run_cyc = 0; e.disp_cyc = 0;
    if (!e.bad) begin
      // Done_i takes 2 edges to reach Done_s plus 1 edge to leave the waiting state.
      case (mode)
        M_OK:    begin e.pass = r;    e.run_cyc = d + 2; e.disp_cyc = h + 2; end
        M_NEVER: begin e.tmo = 1'b1;  e.run_cyc = TMO; end
        default: begin e.pass = r; e.tmo = 1'b1; e.run_cyc = d + 2; e.disp_cyc = TMO; end
      endcase
    end
    return e;
  endfunction

  task automatic run_txn(input int sel, input int mode, input int d, input int h, input bit r,
                         input int ackd, input bit poke);
    int k;
    bit bad;
    bad    = (sel >= NUM);
    t_idx  = bad ? 3'd0 : 3'(sel);
    t_mode = mode; t_d = d; t_h = h; t_r = r;
    exp_q.push_back(make_exp(sel, mode, d, h, r));
    bus.Start = 1'b1; bus.Chip_Sel = SW'(sel);
    @(negedge clk);
    bus.Start = 1'b0; bus.Chip_Sel = SW'($urandom);
    check("busy_after_start", bus.Busy, 1);
    check("pin_sel_after_start", bus.Pin_Sel, sel);
    if (bad) check("bad_sel_report_latency", bus.Result_Valid, 1);
    if (poke) begin
      k = 0;
      while (bus.Run_o == '0 && k < 100) begin @(negedge clk); k++; end
      check("poke_run_seen", int'(bus.Run_o != '0), 1);
      repeat (3) begin
        bus.Start = 1'b1; bus.Chip_Sel = SW'($urandom);
        @(negedge clk);
      end
      bus.Start = 1'b0;
    end
    k = 0;
    while (!bus.Result_Valid && k < 2000) begin @(negedge clk); k++; end
    check("report_reached", bus.Result_Valid, 1);
    repeat (ackd) @(negedge clk);
    bus.Ack = 1'b1;
    @(negedge clk);
    bus.Ack = 1'b0;
    check("idle_after_ack", bus.Busy, 0);
    if (poke) begin
      repeat (4) @(negedge clk);
      check("no_second_run", int'(bus.Busy) + int'(bus.Run_o != '0), 0);
    end
    t_abort = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int k, sel, mode, pct;
    bus.Start = 1'b0; bus.Chip_Sel = '0; bus.Ack = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_busy", bus.Busy, 0);
    check("reset_run", bus.Run_o, 0);
    check("reset_disp", bus.Disp_Rslt_o, 0);
    check("reset_valid", bus.Result_Valid, 0);
    check("reset_flags", {bus.Pass, bus.Timeout, bus.Bad_Sel}, 0);
    check("reset_pin_sel", bus.Pin_Sel, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, M_OK, 10, 3, 1'b1, 2, 1'b0);
    run_txn(1, M_OK, 10, 3, 1'b0, 0, 1'b0);
    run_txn(5, M_NEVER, 1, 1, 1'b1, 1, 1'b0);
    run_txn(9, M_OK, 1, 1, 1'b0, 1, 1'b0);
    run_txn(2, M_OK, 12, 4, 1'b1, 1, 1'b1);
    run_txn(6, M_STUCK, 4, 1, 1'b1, 0, 1'b0);
    run_txn(0, M_OK, 1, 1, 1'b1, 0, 1'b0);

    // Bad select with Ack already high: REPORT lasts a single cycle.
    exp_q.push_back(make_exp(12, M_OK, 1, 1, 1'b0));
    bus.Ack = 1'b1; bus.Start = 1'b1; bus.Chip_Sel = SW'(12);
    @(negedge clk);
    bus.Start = 1'b0;
    check("ack_held_report", bus.Result_Valid, 1);
    @(negedge clk);
    check("ack_held_one_cycle", bus.Result_Valid, 0);
    check("ack_held_idle", bus.Busy, 0);
    bus.Ack = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 99) < 15) sel = $urandom_range(NUM, 15);
      else sel = $urandom_range(0, NUM - 1);
      pct  = $urandom_range(0, 99);
      mode = (pct < 70) ? M_OK : (pct < 85) ? M_NEVER : M_STUCK;
      run_txn(sel, mode, $urandom_range(1, 30), $urandom_range(1, 20), 1'($urandom_range(0, 1)),
              $urandom_range(0, 5), (mode == M_OK) && ($urandom_range(0, 3) == 0));
    end

    // Reset while DISP_RSLT is asserted, then a fresh run.
    t_idx = 3'd3; t_mode = M_STUCK; t_d = 5; t_h = 1; t_r = 1'b1;
    exp_q.push_back(make_exp(3, M_STUCK, 5, 1, 1'b1));
    bus.Start = 1'b1; bus.Chip_Sel = SW'(3);
    @(negedge clk);
    bus.Start = 1'b0;
    k = 0;
    while (bus.Disp_Rslt_o == '0 && k < 100) begin @(negedge clk); k++; end
    check("release_reached", int'(bus.Disp_Rslt_o != '0), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_disp", bus.Disp_Rslt_o, 0);
    check("async_reset_run", bus.Run_o, 0);
    check("async_reset_busy", bus.Busy, 0);
    check("async_reset_valid", bus.Result_Valid, 0);
    check("async_reset_flags", {bus.Pass, bus.Timeout, bus.Bad_Sel}, 0);
    check("async_reset_pin_sel", bus.Pin_Sel, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(4, M_OK, 7, 3, 1'b1, 2, 1'b0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
